// File: rtl/adder_share_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : adder_arb_pkg                                                   |
// | Purpose  : Shared constants and FSM state encoding for adder_share_arb.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package adder_arb_pkg;

  localparam int C_N_REQ_DEF = 4;
  localparam int C_WIDTH_DEF = 32;
  localparam int C_ID_W_DEF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/adder_share_arb_if.sv
// +----------------------------------------------------------------------------+
// | Module   : adder_share_arb_if                                              |
// | Purpose  : Request/response bundle between requesters, consumer and the    |
// |            shared-adder arbiter. req_sub exists only with ADDSUB_SHARE_EN. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface adder_share_arb_if
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = C_N_REQ_DEF,
  parameter int WIDTH = C_WIDTH_DEF,
  parameter int ID_W  = C_ID_W_DEF
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_x;
  logic [N_REQ*WIDTH-1:0] req_y;
  logic [N_REQ-1:0]       req_cin;
`ifdef ADDSUB_SHARE_EN
  logic [N_REQ-1:0]       req_sub;
`endif
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_sum;
  logic                   rsp_cout;
  logic                   busy;

  // Requester / consumer side
  modport master (
`ifdef ADDSUB_SHARE_EN
    output req_sub,
`endif
    output req_valid, req_x, req_y, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

  // Arbiter side
  modport slave (
`ifdef ADDSUB_SHARE_EN
    input  req_sub,
`endif
    input  req_valid, req_x, req_y, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

endinterface

`default_nettype wire

// File: rtl/adder_share_arb_rr_pick.sv
// +----------------------------------------------------------------------------+
// | Module   : rr_pick                                                         |
// | Purpose  : Combinational round-robin picker: first set request at or above |
// |            the pointer, wrapping at N_REQ. One-hot grant + encoded index.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = C_N_REQ_DEF,
  parameter int ID_W  = C_ID_W_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  // One extra bit so ptr+k never overflows before the wrap at N_REQ
  localparam logic [ID_W:0] C_N = (ID_W+1)'(N_REQ);

  logic [ID_W:0] cand;

  // Walk candidates ptr, ptr+1, ... modulo N_REQ and keep the first valid one
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= C_N) cand = cand - C_N;
      if (!any && req[cand[ID_W-1:0]]) begin
        any                  = 1'b1;
        gnt[cand[ID_W-1:0]]  = 1'b1;
        idx                  = cand[ID_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/prefix_adder32.sv
// +----------------------------------------------------------------------------+
// | Module   : prefix_adder32                                                  |
// | Purpose  : 32-bit combinational Kogge-Stone prefix adder with carry in/out.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module prefix_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] prop;
  logic [31:0] g_v;
  logic [31:0] p_v;
  logic [31:0] g_n;
  logic [31:0] p_n;

  // Log-depth generate/propagate prefix tree; cin is folded into bit 0's generate
  always_comb begin
    prop   = a ^ b;
    g_v    = a & b;
    p_v    = prop;
    g_v[0] = g_v[0] | (p_v[0] & cin);
    g_n    = g_v;
    p_n    = p_v;
    for (int l = 0; l < 5; l++) begin
      g_n = g_v;
      p_n = p_v;
      for (int i = (1 << l); i < 32; i++) begin
        g_n[i] = g_v[i] | (p_v[i] & g_v[i - (1 << l)]);
        p_n[i] = p_v[i] & p_v[i - (1 << l)];
      end
      g_v = g_n;
      p_v = p_n;
    end
    sum  = prop ^ {g_v[30:0], cin};
    cout = g_v[31];
  end

endmodule

`default_nettype wire

// File: rtl/adder_share_arb.sv
// +----------------------------------------------------------------------------+
// | Module   : adder_share_arb                                                 |
// | Purpose  : Round-robin time-sharing of one 32-bit prefix adder among N_REQ |
// |            requesters; registered operands and results, tagged response.  |
// |            Optional subtract support with macro ADDSUB_SHARE_EN.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module adder_share_arb
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = C_N_REQ_DEF,
  parameter int WIDTH = C_WIDTH_DEF,
  parameter int ID_W  = C_ID_W_DEF
) (
  input  logic              clk,
  input  logic              rstN,
  adder_share_arb_if.slave  bus
);

  localparam logic [ID_W:0] C_N = (ID_W+1)'(N_REQ);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cin_q, cin_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             busy_q, busy_d;
  logic [ID_W:0]    ptr_inc;

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;

  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // Grants are only offered in IDLE and never while reset is held
  assign bus.req_ready = (state_q == ST_IDLE && rstN) ? gnt : '0;

`ifdef ADDSUB_SHARE_EN
  logic sub_q, sub_d;
  // Subtract is x + ~y + 1; carry-out then reads as not-borrow
  assign add_b   = sub_q ? ~y_q : y_q;
  assign add_cin = sub_q | cin_q;
`else
  assign add_b   = y_q;
  assign add_cin = cin_q;
`endif

  prefix_adder32 u_add (
    .a    (x_q),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state and datapath capture for the IDLE -> CALC -> RESP cycle
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    x_d         = x_q;
    y_d         = y_q;
    cin_d       = cin_q;
    id_d        = id_q;
`ifdef ADDSUB_SHARE_EN
    sub_d       = sub_q;
`endif
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    ptr_inc     = {1'b0, gnt_idx} + (ID_W+1)'(1);
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          x_d     = bus.req_x[int'(gnt_idx)*WIDTH +: WIDTH];
          y_d     = bus.req_y[int'(gnt_idx)*WIDTH +: WIDTH];
          cin_d   = bus.req_cin[gnt_idx];
`ifdef ADDSUB_SHARE_EN
          sub_d   = bus.req_sub[gnt_idx];
`endif
          id_d    = gnt_idx;
          ptr_d   = (ptr_inc == C_N) ? '0 : ptr_inc[ID_W-1:0];
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        rsp_sum_d   = add_sum;
        rsp_cout_d  = add_cout;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, pointer, operand and response registers; reset discards any in-flight op
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      cin_q       <= 1'b0;
      id_q        <= '0;
`ifdef ADDSUB_SHARE_EN
      sub_q       <= 1'b0;
`endif
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cin_q       <= cin_d;
      id_q        <= id_d;
`ifdef ADDSUB_SHARE_EN
      sub_q       <= sub_d;
`endif
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_share_arb.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_adder_share_arb                                              |
// | Purpose  : Self-checking bench for adder_share_arb: vector table, directed |
// |            rotation/backpressure/reset sequences, random vs. ref model.    |
// |            Subtract vectors are added when ADDSUB_SHARE_EN is defined.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_adder_share_arb;

  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int ID_W  = 2;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  adder_share_arb_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  adder_share_arb #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic        sub;
    logic [31:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the definition of the operation
  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic cin, input logic sub);
    if (sub) return {1'b0, x} + {1'b0, ~y} + 33'd1;
    return {1'b0, x} + {1'b0, y} + {32'd0, cin};
  endfunction

  task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y,
                         input logic cin, input logic sub);
    bus.req_x[i*WIDTH +: WIDTH] = x;
    bus.req_y[i*WIDTH +: WIDTH] = y;
    bus.req_cin[i]              = cin;
`ifdef ADDSUB_SHARE_EN
    bus.req_sub[i]              = sub;
`else
    if (sub) $display("note: subtract request ignored in add-only build");
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstN          = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  // One isolated transaction with rsp_ready held high
  task automatic do_txn(input vec_t v, input string tag);
    @(negedge clk);
    bus.req_valid       = '0;
    bus.req_valid[v.id] = 1'b1;
    bus.rsp_ready       = 1'b1;
    set_req(v.id, v.x, v.y, v.cin, v.sub);
    #1;
    chk({tag, ".ready"}, 64'(bus.req_ready), 64'(1) << v.id);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk({tag, ".valid_t1"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
    @(negedge clk);
    #1;
    chk({tag, ".valid_t2"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, ".sum"}, 64'(bus.rsp_sum), 64'(v.exp_sum));
    chk({tag, ".cout"}, 64'(bus.rsp_cout), 64'(v.exp_cout));
    chk({tag, ".id"}, 64'(bus.rsp_id), 64'(v.id));
    @(negedge clk);
    #1;
    chk({tag, ".done"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  // Random-phase model state
  logic [31:0] rx [N_REQ];
  logic [31:0] ry [N_REQ];
  logic        rc [N_REQ];
  logic        rs [N_REQ];
  bit          rv [N_REQ];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hx, hy;
    logic [32:0] hexp;
    vec_t        v;

    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_cin   = '0;
`ifdef ADDSUB_SHARE_EN
    bus.req_sub   = '0;
`endif
    bus.rsp_ready = 1'b1;

    tbl.push_back('{0, 32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0004, 1'b0});
    tbl.push_back('{2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1});
    tbl.push_back('{1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1});
    tbl.push_back('{3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0});
    tbl.push_back('{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1});
    tbl.push_back('{3, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0});
`ifdef ADDSUB_SHARE_EN
    tbl.push_back('{1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0});
    tbl.push_back('{2, 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1});
`endif

    // Outputs during reset, with every requester asking
    bus.req_valid = '1;
    #12;
    chk("rst.req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst.rsp_id",    64'(bus.rsp_id),    64'd0);
    chk("rst.rsp_sum",   64'(bus.rsp_sum),   64'd0);
    chk("rst.rsp_cout",  64'(bus.rsp_cout),  64'd0);
    chk("rst.busy",      64'(bus.busy),      64'd0);
    do_reset();

    // Vector table
    for (int i = 0; i < tbl.size(); i++) do_txn(tbl[i], $sformatf("tbl%0d", i));

    // All requesters valid continuously: strict rotation, one result every 3 cycles
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) set_req(i, 32'h1000 * (i + 1), 32'(i), 1'b0, 1'b0);
    bus.req_valid = '1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rot%0d.grant", k), 64'(bus.req_ready), 64'(1) << (k % N_REQ));
      @(negedge clk); #1;
      chk($sformatf("rot%0d.calc", k), 64'(bus.rsp_valid), 64'd0);
      @(negedge clk); #1;
      chk($sformatf("rot%0d.valid", k), 64'(bus.rsp_valid), 64'd1);
      chk($sformatf("rot%0d.id", k), 64'(bus.rsp_id), 64'(k % N_REQ));
      chk($sformatf("rot%0d.sum", k), 64'(bus.rsp_sum),
          64'(32'h1000 * ((k % N_REQ) + 1) + 32'(k % N_REQ)));
      @(negedge clk); #1;
    end
    bus.req_valid = '0;
    repeat (4) @(negedge clk);

    // Backpressure: result held for 5 cycles, no grant while stalled
    do_reset();
    @(negedge clk);
    hx = 32'hDEAD_BEEF; hy = 32'h1111_1111;
    hexp = ref_add(hx, hy, 1'b1, 1'b0);
    set_req(1, hx, hy, 1'b1, 1'b0);
    set_req(3, 32'h5, 32'h6, 1'b0, 1'b0);
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 4'b1000;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d.valid", c), 64'(bus.rsp_valid), 64'd1);
      chk($sformatf("bp%0d.sum", c), 64'(bus.rsp_sum), 64'(hexp[31:0]));
      chk($sformatf("bp%0d.cout", c), 64'(bus.rsp_cout), 64'(hexp[32]));
      chk($sformatf("bp%0d.id", c), 64'(bus.rsp_id), 64'd1);
      chk($sformatf("bp%0d.ready", c), 64'(bus.req_ready), 64'd0);
      if (c < 4) @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp.released", 64'(bus.rsp_valid), 64'd0);
    chk("bp.next_grant", 64'(bus.req_ready), 64'b1000);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);

    // Reset during CALC: result discarded, pointer back to 0
    do_reset();
    @(negedge clk);
    set_req(2, 32'h100, 32'h200, 1'b0, 1'b0);
    set_req(0, 32'h7, 32'h8, 1'b1, 1'b0);
    bus.req_valid = 4'b0100;
    #1;
    chk("rmid.grant2", 64'(bus.req_ready), 64'b0100);
    @(negedge clk);
    bus.req_valid = 4'b1011;
    rstN = 1'b0;
    #1;
    chk("rmid.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rmid.busy", 64'(bus.busy), 64'd0);
    chk("rmid.ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk); #1;
    chk("rmid.still_none", 64'(bus.rsp_valid), 64'd0);
    rstN = 1'b1;
    #1;
    chk("rmid.first_winner", 64'(bus.req_ready), 64'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk); #1;
    chk("rmid.rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rmid.rsp_sum", 64'(bus.rsp_sum), 64'h10);
    repeat (3) @(negedge clk);

    // Randomized traffic against a transaction-level model
    do_reset();
    begin
      int          mptr  = 0;
      bit          outst = 0;
      int          age   = 0;
      logic [32:0] mexp  = '0;
      int          mid   = 0;
      int          g;
      logic [N_REQ-1:0] eg;
      for (int i = 0; i < N_REQ; i++) rv[i] = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
        @(negedge clk);
        for (int i = 0; i < N_REQ; i++) begin
          if (!rv[i]) begin
            if ($urandom_range(0, 2) == 0) begin
              rv[i] = 1;
              rx[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
              ry[i] = $urandom;
              rc[i] = 1'($urandom_range(0, 1));
`ifdef ADDSUB_SHARE_EN
              rs[i] = 1'($urandom_range(0, 1));
`else
              rs[i] = 1'b0;
`endif
            end
          end else if ($urandom_range(0, 15) == 0) begin
            rv[i] = 0;
          end
          set_req(i, rx[i], ry[i], rc[i], rs[i]);
          bus.req_valid[i] = rv[i];
        end
        bus.rsp_ready = ($urandom_range(0, 2) != 0);
        #1;
        eg = '0;
        g  = -1;
        if (!outst) begin
          for (int k = 0; k < N_REQ; k++) begin
            if (g < 0 && rv[(mptr + k) % N_REQ]) g = (mptr + k) % N_REQ;
          end
          if (g >= 0) eg[g] = 1'b1;
        end
        chk("rnd.req_ready", 64'(bus.req_ready), 64'(eg));
        chk("rnd.busy", 64'(bus.busy), 64'(outst));
        chk("rnd.rsp_valid", 64'(bus.rsp_valid), 64'(outst && age >= 2));
        if (outst && age >= 2) begin
          chk("rnd.sum", 64'(bus.rsp_sum), 64'(mexp[31:0]));
          chk("rnd.cout", 64'(bus.rsp_cout), 64'(mexp[32]));
          chk("rnd.id", 64'(bus.rsp_id), 64'(mid));
        end
        if (g >= 0) begin
          outst = 1;
          age   = 1;
          mexp  = ref_add(rx[g], ry[g], rc[g], rs[g]);
          mid   = g;
          mptr  = (g + 1) % N_REQ;
          rv[g] = 0;
        end else if (outst) begin
          if (age >= 2 && bus.rsp_ready) outst = 0;
          else if (age < 2) age++;
        end
      end
    end

    @(negedge clk);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    v = tbl[0];
    do_txn(v, "final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
